// File: rtl/dsd_dop_packer.sv
// DSD-over-PCM packer: gathers 16 DSD bits MSB-first into a DoP word with an alternating
// 05/FA marker and queues it in a small FIFO. Optional macro DOP_OVF_COUNT_EN adds ovf_count.
module dsd_dop_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dsd_bit,
  input  logic        dsd_ce,
  output logic [23:0] dop_word,
  output logic        dop_valid,
  input  logic        dop_ready,
  output logic        overflow
`ifdef DOP_OVF_COUNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   shift_q, shift_d;
  logic          marker_q, marker_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic        word_done, full, push, pop, drop;
  logic [23:0] new_word;

  // Handshake: a word transfers on every rising edge where dop_valid and dop_ready are
  // both high; dop_word holds the FIFO head and cannot change while dop_valid && !dop_ready.
  assign dop_valid = (count_q != '0);
  assign dop_word  = dop_valid ? mem_q[rd_ptr_q] : 24'h000000;
  assign overflow  = overflow_q;

  assign word_done = dsd_ce && (bit_cnt_q == 4'd15);
  assign full      = (count_q == FULL_CNT);
  assign pop       = dop_valid && dop_ready;
  assign push      = word_done && (!full || pop);
  assign drop      = word_done && full && !pop;
  assign new_word  = {(marker_q ? 8'hFA : 8'h05), shift_q, dsd_bit};

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    marker_d   = marker_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = drop;
    // Sampling never stalls; the 4-bit counter wraps on the 16th bit.
    if (dsd_ce) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
      shift_d   = {shift_q[13:0], dsd_bit};
    end
    // Marker toggles only on accepted words, so dropped words keep the alternation intact.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      marker_d = ~marker_q;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      marker_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      marker_q   <= marker_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: reads are masked by dop_valid.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= new_word;
  end

`ifdef DOP_OVF_COUNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_dsd_dop_packer.sv
// Bench for dsd_dop_packer: word-level reference model (bit list -> word queue) compared
// against the DUT after every driven cycle. Define DOP_OVF_COUNT_EN to also cover ovf_count.
module tb_dsd_dop_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dsd_bit = 1'b0;
  logic        dsd_ce = 1'b0;
  logic        dop_ready = 1'b0;
  logic [23:0] dop_word;
  logic        dop_valid;
  logic        overflow;
`ifdef DOP_OVF_COUNT_EN
  logic [15:0] ovf_count;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [23:0] exp_q[$];
  int          m_n;
  logic [15:0] m_pay;
  logic        m_mark;
  logic        m_ovf;
  int          m_ovf_cnt;
  logic [23:0] exp_head;
  logic        exp_valid;

  dsd_dop_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .dsd_bit   (dsd_bit),
    .dsd_ce    (dsd_ce),
    .dop_word  (dop_word),
    .dop_valid (dop_valid),
    .dop_ready (dop_ready),
    .overflow  (overflow)
`ifdef DOP_OVF_COUNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded budget", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver: apply one cycle of inputs, advance the model, wait until just after the edge.
  task automatic step(input logic r, input logic ce, input logic b, input logic rdy);
    logic was_full;
    logic do_pop;
    logic [23:0] tmp;
    rst = r; dsd_ce = ce; dsd_bit = b; dop_ready = rdy;
    if (r) begin
      exp_q.delete();
      m_n = 0; m_pay = '0; m_mark = 1'b0; m_ovf = 1'b0; m_ovf_cnt = 0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      do_pop = rdy && (exp_q.size() > 0);
      m_ovf = 1'b0;
      if (do_pop) tmp = exp_q.pop_front();
      if (ce) begin
        m_pay = m_pay | (16'(b) << (15 - m_n));
        if (m_n == 15) begin
          if (!was_full || do_pop) begin
            exp_q.push_back({(m_mark ? 8'hFA : 8'h05), m_pay});
            m_mark = ~m_mark;
          end else begin
            m_ovf = 1'b1;
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
          end
          m_n = 0;
          m_pay = '0;
        end else begin
          m_n++;
        end
      end
    end
    exp_valid = (exp_q.size() > 0);
    exp_head  = exp_valid ? exp_q[0] : 24'h000000;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dop_valid); end
    n_checks++;
    if (dop_word !== 24'h000000) begin n_fail++; $display("FAIL reset_word: got %h expected 000000", dop_word); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_patterns();
    logic [23:0] want [3];
    want[0] = 24'h05AAAA; want[1] = 24'hFAFFFF; want[2] = 24'h050000;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, (p == 0) ? ((i % 2) == 0) : (p == 1), 1'b1);
        if (i == 14) begin
          n_checks++;
          if (dop_valid !== 1'b0) begin n_fail++; $display("FAIL pat%0d_early: valid got %b expected 0", p, dop_valid); end
        end
      end
      n_checks++;
      if (dop_valid !== 1'b1) begin n_fail++; $display("FAIL pat%0d_valid: got %b expected 1", p, dop_valid); end
      n_checks++;
      if (dop_word !== want[p]) begin n_fail++; $display("FAIL pat%0d_word: got %h expected %h", p, dop_word, want[p]); end
      n_checks++;
      if (dop_word !== exp_head) begin n_fail++; $display("FAIL pat%0d_model: got %h expected %h", p, dop_word, exp_head); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (dop_valid !== 1'b0) begin n_fail++; $display("FAIL pat%0d_oneshot: valid got %b expected 0", p, dop_valid); end
    end
  endtask

  task automatic test_overflow();
    int ovf_seen;
    logic [7:0] mk [4];
    mk[0] = 8'h05; mk[1] = 8'hFA; mk[2] = 8'h05; mk[3] = 8'hFA;
    ovf_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        if (overflow === 1'b1) ovf_seen++;
        n_checks++;
        if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_pulse w%0d b%0d: got %b expected %b", w, i, overflow, m_ovf); end
      end
    end
    n_checks++;
    if (ovf_seen != 1) begin n_fail++; $display("FAIL ovf_count_pulses: got %0d expected 1", ovf_seen); end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (dop_valid !== 1'b1 || dop_word[23:16] !== mk[k]) begin
        n_fail++; $display("FAIL ovf_marker%0d: got valid %b marker %h expected 1 %h", k, dop_valid, dop_word[23:16], mk[k]);
      end
      n_checks++;
      if (dop_word !== exp_head) begin n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", k, dop_word, exp_head); end
      step(1'b0, 1'b0, 1'b0, 1'b1);
    end
    n_checks++;
    if (dop_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: valid got %b expected 0", dop_valid); end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    n_checks++;
    if (dop_word[23:16] !== 8'h05 || dop_word !== exp_head) begin
      n_fail++; $display("FAIL ovf_after_marker: got %h expected %h", dop_word, exp_head);
    end
  endtask

  task automatic test_full_pop();
    logic [23:0] head0;
    logic [23:0] last;
    int n;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4 * 16 + 15; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    head0 = exp_head;
    n_checks++;
    if (dop_word !== head0) begin n_fail++; $display("FAIL full_head: got %h expected %h", dop_word, head0); end
    step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_pop_ovf: got %b expected 0", overflow); end
    n = 0;
    last = '0;
    while (dop_valid === 1'b1 && n < 8) begin
      n_checks++;
      if (dop_word !== exp_head) begin n_fail++; $display("FAIL full_drain%0d: got %h expected %h", n, dop_word, exp_head); end
      last = dop_word;
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    n_checks++;
    if (n != DEPTH) begin n_fail++; $display("FAIL full_occupancy: got %0d expected %0d", n, DEPTH); end
    n_checks++;
    if (last[23:16] !== 8'h05) begin n_fail++; $display("FAIL full_last_marker: got %h expected 05", last[23:16]); end
  endtask

  task automatic test_reset_midword();
    logic [15:0] bits;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (dop_valid !== 1'b0 || dop_word !== 24'h000000) begin
      n_fail++; $display("FAIL mid_reset: got valid %b word %h expected 0 000000", dop_valid, dop_word);
    end
    bits = 16'($urandom());
    for (int i = 15; i >= 0; i--) step(1'b0, 1'b1, bits[i], 1'b1);
    n_checks++;
    if (dop_valid !== 1'b1 || dop_word !== {8'h05, bits}) begin
      n_fail++; $display("FAIL mid_word: got %h expected %h", dop_word, {8'h05, bits});
    end
  endtask

  task automatic test_random();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3));
      n_checks++;
      if (dop_valid !== exp_valid || dop_word !== exp_head || overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_c%0d: got v%b w%h o%b expected v%b w%h o%b", c,
                 dop_valid, dop_word, overflow, exp_valid, exp_head, m_ovf);
      end
    end
  endtask

`ifdef DOP_OVF_COUNT_EN
  task automatic test_ovf_count();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7 * 16; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
    n_checks++;
    if (ovf_count !== 16'd3 || m_ovf_cnt != 3) begin
      n_fail++; $display("FAIL ovf_count_3: got %0d expected 3", ovf_count);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL ovf_count_rst: got %0d expected 0", ovf_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_patterns();
    test_overflow();
    test_full_pop();
    test_reset_midword();
    test_random();
`ifdef DOP_OVF_COUNT_EN
    test_ovf_count();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
